// File: rtl/rtc_ctrl_pkg.sv
// Shared types for the stopwatch controller: FSM state encoding, per-state output decode,
// and the default debounce length.
package rtc_ctrl_pkg;

   localparam int unsigned DEBOUNCE_CYCLES_DEF = 20;

   typedef enum logic [2:0] {
      ST_INIT = 3'd0,
      ST_IDLE = 3'd1,
      ST_RUN  = 3'd2,
      ST_LAP  = 3'd3,
      ST_STOP = 3'd4
   } state_e;

   typedef struct packed {
      logic countinit;
      logic countenb;
      logic latchcount;
      logic lap_active;
   } ctrl_out_t;

   localparam ctrl_out_t OUT_INIT = 4'b1010;
   localparam ctrl_out_t OUT_IDLE = 4'b0010;
   localparam ctrl_out_t OUT_RUN  = 4'b0110;
   localparam ctrl_out_t OUT_LAP  = 4'b0101;
   localparam ctrl_out_t OUT_STOP = 4'b0010;

   function automatic ctrl_out_t decode_outputs(input state_e s);
      ctrl_out_t o;
      case (s)
         ST_INIT: o = OUT_INIT;
         ST_IDLE: o = OUT_IDLE;
         ST_RUN:  o = OUT_RUN;
         ST_LAP:  o = OUT_LAP;
         ST_STOP: o = OUT_STOP;
         default: o = OUT_INIT;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/rtc_button_debounce.sv
// One push-button path: 2-flop synchroniser, stable-count debounce, one-cycle press pulse.
// Press pulse is high in the cycle after edge DEBOUNCE_CYCLES+3 counted from the first raw-high sample.
module rtc_button_debounce
   import rtc_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic i_sclk,
   input  logic i_reset_n,
   input  logic i_btn,
   output logic o_press
);

   localparam int unsigned      CNT_W    = 16;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             level_prev_q, level_prev_d;
   logic             press_q, press_d;
   logic [1:0]       warm_q, warm_d;
   logic             armed_q, armed_d;

   always_comb begin
      sync1_d      = i_btn;
      sync2_d      = sync1_q;
      cnt_d        = '0;
      level_d      = level_q;
      level_prev_d = level_q;
      warm_d       = {warm_q[0], 1'b1};
      // A button held through reset stays disarmed until it is seen released.
      armed_d      = armed_q | (warm_q[1] & ~sync2_q);
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = ~level_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      press_d = level_q & ~level_prev_q & armed_q;
   end

   always_ff @(posedge i_sclk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         cnt_q        <= '0;
         level_q      <= 1'b0;
         level_prev_q <= 1'b0;
         press_q      <= 1'b0;
         warm_q       <= 2'b00;
         armed_q      <= 1'b0;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         cnt_q        <= cnt_d;
         level_q      <= level_d;
         level_prev_q <= level_prev_d;
         press_q      <= press_d;
         warm_q       <= warm_d;
         armed_q      <= armed_d;
      end
   end

   assign o_press = press_q;

endmodule

// File: rtl/rtc_stopwatch_ctrl.sv
// Stopwatch mode FSM (INIT/IDLE/RUN/LAP/STOP) with registered counter/display controls and lap count.
// Define RTC_STOPWATCH_LAP_EN to build the LAP state and lap counter; otherwise they are compiled out.
module rtc_stopwatch_ctrl
   import rtc_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned LAP_W           = 4
) (
   input  logic             i_sclk,
   input  logic             i_reset_n,
   input  logic             i_start_stop,
   input  logic             i_lap_reset,
   output logic             o_countinit,
   output logic             o_countenb,
   output logic             o_latchcount,
   output logic             o_lap_active,
   output logic [LAP_W-1:0] o_lap_count
);

   logic      ss_press;
   logic      lr_press;
   state_e    state_q, state_d;
   ctrl_out_t ctrl_q, ctrl_d;

   rtc_button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ss_db (
      .i_sclk    (i_sclk),
      .i_reset_n (i_reset_n),
      .i_btn     (i_start_stop),
      .o_press   (ss_press)
   );

   rtc_button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lr_db (
      .i_sclk    (i_sclk),
      .i_reset_n (i_reset_n),
      .i_btn     (i_lap_reset),
      .o_press   (lr_press)
   );

   // start/stop is tested first everywhere, so it wins a same-cycle collision.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_INIT: state_d = ST_IDLE;
         ST_IDLE: begin
            if (ss_press)      state_d = ST_RUN;
            else if (lr_press) state_d = ST_INIT;
         end
         ST_RUN: begin
            if (ss_press)      state_d = ST_STOP;
`ifdef RTC_STOPWATCH_LAP_EN
            else if (lr_press) state_d = ST_LAP;
`endif
         end
`ifdef RTC_STOPWATCH_LAP_EN
         ST_LAP: begin
            if (ss_press)      state_d = ST_STOP;
            else if (lr_press) state_d = ST_RUN;
         end
`endif
         ST_STOP: begin
            if (ss_press)      state_d = ST_RUN;
            else if (lr_press) state_d = ST_INIT;
         end
         default: state_d = ST_INIT;
      endcase

      ctrl_d = decode_outputs(state_d);
`ifndef RTC_STOPWATCH_LAP_EN
      ctrl_d.lap_active = 1'b0;
`endif
   end

   always_ff @(posedge i_sclk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= ST_INIT;
         ctrl_q  <= OUT_INIT;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
      end
   end

   assign o_countinit  = ctrl_q.countinit;
   assign o_countenb   = ctrl_q.countenb;
   assign o_latchcount = ctrl_q.latchcount;
   assign o_lap_active = ctrl_q.lap_active;

`ifdef RTC_STOPWATCH_LAP_EN
   logic [LAP_W-1:0] lap_cnt_q, lap_cnt_d;

   always_comb begin
      lap_cnt_d = lap_cnt_q;
      if (state_d == ST_INIT) begin
         lap_cnt_d = '0;
      end else if ((state_q == ST_RUN) && (state_d == ST_LAP) && (lap_cnt_q != {LAP_W{1'b1}})) begin
         lap_cnt_d = lap_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge i_sclk or negedge i_reset_n) begin
      if (!i_reset_n) lap_cnt_q <= '0;
      else            lap_cnt_q <= lap_cnt_d;
   end

   assign o_lap_count = lap_cnt_q;
`else
   assign o_lap_count = '0;
`endif

endmodule
